// File: rtl/mips8_pkg.sv
// rtl/mips8_pkg.sv - shared opcodes, instruction fields and sequencer states
package mips8_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LW  = 2'b10;
  localparam logic [1:0] OP_SW  = 2'b11;

  // Instruction layout: [7:6] opcode, [5:4] rs, [3:2] rt, [1:0] rd
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int RS_MSB = 5;
  localparam int RS_LSB = 4;
  localparam int RT_MSB = 3;
  localparam int RT_LSB = 2;
  localparam int RD_MSB = 1;
  localparam int RD_LSB = 0;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_RFWAIT = 4'd3,
    ST_EXEC   = 4'd4,
    ST_MEM    = 4'd5,
    ST_WB     = 4'd6,
    ST_RETIRE = 4'd7,
    ST_ERROR  = 4'd8
  } state_t;

endpackage

// File: rtl/mips8_mem_timeout.sv
// rtl/mips8_mem_timeout.sv - wait counter for a pending memory access
module mips8_mem_timeout
  import mips8_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active_i,
  input  logic ready_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count consecutive unanswered cycles; anything other than a stalled access restarts at zero,
  // which also clears the count on every entry to a memory-access state.
  always_comb begin
    cnt_d = '0;
    if (active_i && !ready_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A ready on the final allowed cycle still completes the access, so expiry requires !ready.
  assign expired_o = active_i && !ready_i && (cnt_q == CW'(TIMEOUT - 1));

  // Wait counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mips8_ctrl_fsm.sv
// rtl/mips8_ctrl_fsm.sv - multicycle control sequencer for the 8-bit MIPS datapath
module mips8_ctrl_fsm
  import mips8_pkg::*;
#(
  parameter int REG_AW  = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              alu_zero,
  output logic              mem_read,
  output logic              mem_write,
  output logic              addr_sel,
  output logic              pc_write,
  output logic [REG_AW-1:0] rf_read_addr1,
  output logic [REG_AW-1:0] rf_read_addr2,
  output logic [REG_AW-1:0] rf_write_addr,
  output logic              rf_write_enable,
  output logic              wb_sel,
  output logic              alu_op,
  output logic              busy,
  output logic              error,
  output logic [7:0]        instr_count
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [7:0]        instr_count_q, instr_count_d;
  logic              error_q, error_d;
  logic [1:0]        op;
  logic              mem_wait;
  logic              mem_expired;
  logic              unused_alu_zero;

  // The ISA has no branches, so the zero flag is accepted but deliberately ignored.
  assign unused_alu_zero = alu_zero;

  assign op       = ir_q[OP_MSB:OP_LSB];
  assign mem_wait = (state_q == ST_FETCH) || (state_q == ST_MEM);

  mips8_mem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .active_i  (mem_wait),
    .ready_i   (mem_ready),
    .expired_o (mem_expired)
  );

  assign rf_read_addr1 = ir_q[RS_MSB:RS_LSB];
  assign rf_read_addr2 = ir_q[RT_MSB:RT_LSB];
  assign rf_write_addr = ir_q[RD_MSB:RD_LSB];
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign error         = error_q;
  assign instr_count   = instr_count_q;

  // Next-state, instruction latch, retire counter and strobe decode.
  always_comb begin
    state_d         = state_q;
    ir_d            = ir_q;
    instr_count_d   = instr_count_q;
    error_d         = error_q;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    addr_sel        = 1'b0;
    pc_write        = 1'b0;
    rf_write_enable = 1'b0;
    wb_sel          = 1'b0;
    alu_op          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_read = 1'b1;
        // PC advances only on the completing cycle so wait states do not skip instructions.
        pc_write = mem_ready;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = ST_DECODE;
        end else if (mem_expired) begin
          error_d = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_DECODE: begin
        state_d = ST_RFWAIT;
      end
      ST_RFWAIT: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if ((op == OP_ADD) || (op == OP_SUB)) begin
          alu_op  = ir_q[OP_LSB];
          state_d = ST_WB;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        addr_sel = 1'b1;
        if (op == OP_LW) begin
          mem_read = 1'b1;
        end else begin
          mem_write = 1'b1;
        end
        if (mem_ready) begin
          state_d = (op == OP_LW) ? ST_WB : ST_RETIRE;
        end else if (mem_expired) begin
          error_d = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_WB: begin
        rf_write_enable = 1'b1;
        wb_sel          = (op == OP_LW);
        state_d         = ST_RETIRE;
      end
      ST_RETIRE: begin
        instr_count_d = instr_count_q + 8'd1;
        state_d       = run ? ST_FETCH : ST_IDLE;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and architectural registers; reset drops every strobe without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ir_q          <= '0;
      instr_count_q <= 8'd0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      instr_count_q <= instr_count_d;
      error_q       <= error_d;
    end
  end

endmodule

// File: tb/tb_mips8_ctrl_fsm.sv
// tb/tb_mips8_ctrl_fsm.sv - randomized self-checking bench for mips8_ctrl_fsm
module tb_mips8_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       alu_zero;
  logic       mem_read, mem_write, addr_sel, pc_write;
  logic [1:0] rf_read_addr1, rf_read_addr2, rf_write_addr;
  logic       rf_write_enable, wb_sel, alu_op, busy, error;
  logic [7:0] instr_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips8_ctrl_fsm dut (
    .clk             (clk),
    .reset           (reset),
    .run             (run),
    .mem_rdata       (mem_rdata),
    .mem_ready       (mem_ready),
    .alu_zero        (alu_zero),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .addr_sel        (addr_sel),
    .pc_write        (pc_write),
    .rf_read_addr1   (rf_read_addr1),
    .rf_read_addr2   (rf_read_addr2),
    .rf_write_addr   (rf_write_addr),
    .rf_write_enable (rf_write_enable),
    .wb_sel          (wb_sel),
    .alu_op          (alu_op),
    .busy            (busy),
    .error           (error),
    .instr_count     (instr_count)
  );

  // Strobe vector bit positions: {mem_read, mem_write, addr_sel, pc_write, rf_we, wb_sel, alu_op, busy}
  localparam logic [7:0] O_MR   = 8'h80;
  localparam logic [7:0] O_MW   = 8'h40;
  localparam logic [7:0] O_AS   = 8'h20;
  localparam logic [7:0] O_PC   = 8'h10;
  localparam logic [7:0] O_WE   = 8'h08;
  localparam logic [7:0] O_WB   = 8'h04;
  localparam logic [7:0] O_ALU  = 8'h02;
  localparam logic [7:0] O_BUSY = 8'h01;

  // One expected clock cycle: inputs to apply and outputs that must result.
  typedef struct {
    logic       ready;
    logic [7:0] rdata;
    logic       rn;
    logic [7:0] outs;
    logic [7:0] ir;
    logic [7:0] cnt;
    logic       err;
  } cyc_t;

  cyc_t       q[$];
  logic [7:0] m_ir;
  logic [7:0] m_cnt;

  function automatic logic [7:0] strobes();
    return {mem_read, mem_write, addr_sel, pc_write, rf_write_enable, wb_sel, alu_op, busy};
  endfunction

  task automatic push(input logic rdy, input logic [7:0] rd, input logic rn,
                      input logic [7:0] outs, input logic err);
    cyc_t c;
    c.ready = rdy;
    c.rdata = rd;
    c.rn    = rn;
    c.outs  = outs;
    c.ir    = m_ir;
    c.cnt   = m_cnt;
    c.err   = err;
    q.push_back(c);
  endtask

  // An idle cycle with run raised: the next cycle begins a fetch.
  task automatic model_start();
    push(1'($urandom), 8'($urandom), 1'b1, 8'h00, 1'b0);
  endtask

  // Timeline of one instruction built from the ISA rules: fetch (with waits), decode,
  // register read wait, execute, optional memory (with waits), optional write-back, retire.
  task automatic model_instr(input logic [7:0] instr, input int wf, input int wm, input bit keep);
    logic [1:0] op;
    logic [7:0] mo;
    logic [7:0] eo;
    op = instr[7:6];
    for (int i = 0; i < wf; i++) push(1'b0, 8'($urandom), 1'b1, O_MR | O_BUSY, 1'b0);
    push(1'b1, instr, 1'b1, O_MR | O_PC | O_BUSY, 1'b0);
    m_ir = instr;
    push(1'($urandom), 8'($urandom), 1'b1, O_BUSY, 1'b0);
    push(1'($urandom), 8'($urandom), 1'b1, O_BUSY, 1'b0);
    eo = O_BUSY;
    if (op == 2'b01) eo = eo | O_ALU;
    push(1'($urandom), 8'($urandom), keep, eo, 1'b0);
    if (op[1]) begin
      mo = O_AS | O_BUSY | ((op == 2'b10) ? O_MR : O_MW);
      for (int i = 0; i < wm; i++) push(1'b0, 8'($urandom), keep, mo, 1'b0);
      push(1'b1, 8'($urandom), keep, mo, 1'b0);
    end
    if (op != 2'b11) push(1'($urandom), 8'($urandom), keep, O_WE | O_BUSY | ((op == 2'b10) ? O_WB : 8'h00), 1'b0);
    push(1'($urandom), 8'($urandom), keep, O_BUSY, 1'b0);
    m_cnt = m_cnt + 8'd1;
    if (!keep) push(1'($urandom), 8'($urandom), 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; mem_rdata = 8'h00; alu_zero = 1'b0;
    m_ir = 8'h00; m_cnt = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (strobes() !== 8'h00) begin errors++; $display("FAIL reset.strobes got=%b want=%b", strobes(), 8'h00); end
    checks++;
    if (instr_count !== 8'd0 || error !== 1'b0) begin
      errors++; $display("FAIL reset.count_err got=%0d/%b want=0/0", instr_count, error);
    end
    checks++;
    if ({rf_read_addr1, rf_read_addr2, rf_write_addr} !== 6'd0) begin
      errors++; $display("FAIL reset.addrs got=%b want=000000", {rf_read_addr1, rf_read_addr2, rf_write_addr});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    cyc_t c;
    int   n = 0;
    model_start();
    model_instr(8'b00_01_10_11, 0, 0, 1'b1);
    model_instr(8'b10_10_00_01, 0, 3, 1'b1);
    model_instr(8'b11_00_01_00, 0, 0, 1'b1);
    model_instr(8'b01_11_00_10, 2, 0, 1'b0);
    model_start();
    model_instr(8'b00_11_11_00, 14, 0, 1'b0);
    while (q.size() != 0) begin
      c = q.pop_front();
      @(negedge clk);
      mem_ready = c.ready; mem_rdata = c.rdata; run = c.rn;
      #1;
      checks++;
      if (strobes() !== c.outs) begin errors++; $display("FAIL directed.strobes cyc=%0d got=%b want=%b", n, strobes(), c.outs); end
      checks++;
      if ({rf_read_addr1, rf_read_addr2, rf_write_addr} !== c.ir[5:0]) begin
        errors++; $display("FAIL directed.addrs cyc=%0d got=%b want=%b", n, {rf_read_addr1, rf_read_addr2, rf_write_addr}, c.ir[5:0]);
      end
      checks++;
      if (instr_count !== c.cnt) begin errors++; $display("FAIL directed.count cyc=%0d got=%0d want=%0d", n, instr_count, c.cnt); end
      checks++;
      if (error !== c.err) begin errors++; $display("FAIL directed.error cyc=%0d got=%b want=%b", n, error, c.err); end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c;
    int   n = 0;
    int   base;
    int   wf, wm;
    base = int'(m_cnt);
    model_start();
    for (int k = 0; k < 260; k++) begin
      wf = ($urandom_range(9, 0) == 0) ? $urandom_range(14, 3) : $urandom_range(1, 0);
      wm = ($urandom_range(9, 0) == 0) ? $urandom_range(14, 3) : $urandom_range(1, 0);
      model_instr(8'($urandom), wf, wm, k != 259);
    end
    while (q.size() != 0) begin
      c = q.pop_front();
      @(negedge clk);
      mem_ready = c.ready; mem_rdata = c.rdata; run = c.rn;
      #1;
      checks++;
      if (strobes() !== c.outs) begin errors++; $display("FAIL b2b.strobes cyc=%0d got=%b want=%b", n, strobes(), c.outs); end
      checks++;
      if ({rf_read_addr1, rf_read_addr2, rf_write_addr} !== c.ir[5:0]) begin
        errors++; $display("FAIL b2b.addrs cyc=%0d got=%b want=%b", n, {rf_read_addr1, rf_read_addr2, rf_write_addr}, c.ir[5:0]);
      end
      checks++;
      if (instr_count !== c.cnt) begin errors++; $display("FAIL b2b.count cyc=%0d got=%0d want=%0d", n, instr_count, c.cnt); end
      checks++;
      if (error !== c.err) begin errors++; $display("FAIL b2b.error cyc=%0d got=%b want=%b", n, error, c.err); end
      n++;
    end
    checks++;
    if (instr_count !== 8'((base + 260) % 256)) begin
      errors++; $display("FAIL b2b.wrap got=%0d want=%0d", instr_count, (base + 260) % 256);
    end
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    run = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (strobes() !== (O_MR | O_BUSY)) begin errors++; $display("FAIL midreset.fetch got=%b want=%b", strobes(), O_MR | O_BUSY); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (strobes() !== 8'h00) begin errors++; $display("FAIL midreset.strobes got=%b want=%b", strobes(), 8'h00); end
    checks++;
    if (instr_count !== 8'd0 || error !== 1'b0) begin
      errors++; $display("FAIL midreset.count_err got=%0d/%b want=0/0", instr_count, error);
    end
    checks++;
    if ({rf_read_addr1, rf_read_addr2, rf_write_addr} !== 6'd0) begin
      errors++; $display("FAIL midreset.addrs got=%b want=000000", {rf_read_addr1, rf_read_addr2, rf_write_addr});
    end
    @(negedge clk);
    reset = 1'b0; run = 1'b0;
    m_ir = 8'h00; m_cnt = 8'h00;
  endtask

  task automatic test_timeout();
    cyc_t c;
    int   n = 0;
    model_start();
    for (int i = 0; i < 15; i++) push(1'b0, 8'($urandom), 1'b1, O_MR | O_BUSY, 1'b0);
    for (int i = 0; i < 6; i++) push(1'($urandom), 8'($urandom), 1'b1, 8'h00, 1'b1);
    while (q.size() != 0) begin
      c = q.pop_front();
      @(negedge clk);
      mem_ready = c.ready; mem_rdata = c.rdata; run = c.rn;
      #1;
      checks++;
      if (strobes() !== c.outs) begin errors++; $display("FAIL timeout.strobes cyc=%0d got=%b want=%b", n, strobes(), c.outs); end
      checks++;
      if (error !== c.err) begin errors++; $display("FAIL timeout.error cyc=%0d got=%b want=%b", n, error, c.err); end
      checks++;
      if (instr_count !== c.cnt) begin errors++; $display("FAIL timeout.count cyc=%0d got=%0d want=%0d", n, instr_count, c.cnt); end
      n++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (error !== 1'b0 || strobes() !== 8'h00) begin
      errors++; $display("FAIL timeout.reset_clears got=%b/%b want=0/00000000", error, strobes());
    end
    @(negedge clk);
    reset = 1'b0; run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_fetch();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips8_ctrl_fsm.md
Name: mips8_ctrl_fsm

Overview:
Multicycle control sequencer for the 8-bit MIPS datapath. Fetches one 8-bit instruction per pass over a ready-handshaked memory port, latches it, and drives the 4x8 register file read/write addresses, write enable, ALU op and memory strobes. Accounts for the register file's one-cycle synchronous read latency with an explicit wait state. Sits between instruction/data memory and the datapath, above the register file and ALU.

Parameters:
REG_AW, 2, register address width (4 registers)
DATA_W, 8, instruction/data width
TIMEOUT, 15, max cycles waiting on mem_ready before entering ERROR (width ceil(log2(TIMEOUT+1)))

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
run  in  1  level; 1 = keep executing, 0 = stop at next instruction boundary
mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1 during a read
mem_ready  in  1  memory handshake: access completes this cycle
alu_zero  in  1  unused by the ISA; reserved
mem_read  out  1  memory read strobe (fetch or LW)
mem_write  out  1  memory write strobe (SW)
addr_sel  out  1  0 = address from PC, 1 = address from rs read data
pc_write  out  1  PC <= PC+1 this cycle
rf_read_addr1  out  REG_AW  = ir[5:4] (rs)
rf_read_addr2  out  REG_AW  = ir[3:2] (rt)
rf_write_addr  out  REG_AW  = ir[1:0] (rd)
rf_write_enable  out  1  register file write strobe
wb_sel  out  1  0 = ALU result, 1 = memory data
alu_op  out  1  0 = ADD, 1 = SUB
busy  out  1  1 whenever state != IDLE and != ERROR
error  out  1  sticky memory timeout flag
instr_count  out  8  retired instructions, wraps 255->0

Behaviour:
- ISA: ir[7:6] opcode; 00 ADD rd<=rs+rt; 01 SUB rd<=rs-rt; 10 LW rd<=mem[rs]; 11 SW mem[rs]<=rt.
- Reset (async): state=IDLE, ir=0, instr_count=0, error=0, wait counter=0; all strobes 0. rf addresses follow ir, so all read 0.
- All strobes are Moore outputs decoded from state (+ir); address outputs are ir bit-fields.
- States/transitions:
  IDLE: run=1 -> FETCH.
  FETCH: mem_read=1, addr_sel=0; on mem_ready: ir<=mem_rdata, pc_write=1 -> DECODE.
  DECODE: one cycle; rf addresses valid from new ir -> RFWAIT.
  RFWAIT: one cycle; register file read data valid at end -> EXEC.
  EXEC: alu_op=ir[6] for ADD/SUB -> WB; LW/SW -> MEM.
  MEM: addr_sel=1; LW: mem_read=1; SW: mem_write=1; on mem_ready: LW -> WB, SW -> RETIRE.
  WB: rf_write_enable=1, wb_sel=(opcode==10), one cycle -> RETIRE.
  RETIRE: instr_count+=1; run=1 -> FETCH, else IDLE.
  ERROR: all strobes 0; exits only via reset.
- Latency: ADD/SUB = fetch cycles + 4 (DECODE, RFWAIT, EXEC, WB) + RETIRE; with zero-wait memory ADD = 6 cycles, LW = 7, SW = 6.
- Handshake: strobes held continuously until mem_ready; no access abandoned except by timeout/reset.
- Timeout: wait counter clears on entry to FETCH/MEM, increments each cycle without mem_ready; reaching TIMEOUT -> ERROR, error<=1. Completion on the same cycle counter hits TIMEOUT wins (access completes).
- run deasserted mid-instruction: instruction completes, stops at RETIRE.
- Write to r0 is permitted (no hardwired zero).
- Reset mid-operation: immediate return to IDLE; any in-flight write strobe drops asynchronously.

Decomposition:
- Package mips8_pkg: opcode constants (OP_ADD..OP_SW), state enum encoding, field bit positions.
- One sub-module natural: mips8_mem_timeout (wait counter + expiry flag), instantiated once.

Test Plan:
- Reset/idle: reset=1 mid-FETCH -> all strobes 0, busy=0, instr_count=0 next cycle without clk edge.
- ADD zero-wait: run=1, mem_rdata=8'b00_01_10_11, mem_ready=1 -> rf_read_addr1=1, addr2=2, rf_write_enable=1 with rf_write_addr=3, wb_sel=0 exactly 5 cycles after FETCH entry; instr_count=1.
- LW with 3-cycle waits: opcode 10, rs=2, rd=1 -> mem_read held in MEM for 3 cycles, then WB with wb_sel=1, rf_write_addr=1.
- SW: 8'b11_00_01_00 -> mem_write=1, addr_sel=1 in MEM; rf_write_enable never asserted.
- Timeout: mem_ready=0 held in FETCH -> error=1 and ERROR after TIMEOUT cycles; stays until reset.
- run drop + wrap: run=0 during EXEC -> instruction retires, IDLE; 256 retirements -> instr_count=0.
